// File: rtl/dmem_arb_pkg.sv
// Shared constants and types for the two-master data-memory arbiter.
// Imported by the picker and by the arbiter top.
package dmem_arb_pkg;

  localparam int unsigned MEM_BYTES_DEFAULT = 128;
  localparam int unsigned MID_W             = 1;
  localparam logic [1:0]  ALIGN_MASK        = 2'b11;

  typedef enum logic [1:0] {
    RESP_NONE = 2'd0,
    RESP_OK   = 2'd1,
    RESP_ERR  = 2'd2
  } resp_state_e;

endpackage

// File: rtl/dmem_arbiter_rr_pick2.sv
// Two-way round-robin picker. Purely combinational; the owner of the
// priority register feeds prio_i and updates it from winner_o.
module rr_pick2
  import dmem_arb_pkg::*;
(
  input  logic [1:0]       req_i,
  input  logic [MID_W-1:0] prio_i,
  output logic [1:0]       gnt_o,
  output logic [MID_W-1:0] winner_o,
  output logic             any_o
);

  always_comb begin
    // NOTE: every output gets a default first so no path through the block can infer a latch.
    winner_o = '0;
    gnt_o    = 2'b00;
    any_o    = |req_i;
    if (req_i == 2'b11) begin
      winner_o = prio_i;
    end else if (req_i[1]) begin
      winner_o = 1'b1;
    end
    if (any_o) begin
      gnt_o = winner_o[0] ? 2'b10 : 2'b01;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares one single-ported data memory between the CPU (m0) and a debug/DMA
// port (m1): round-robin grant, legality check, registered response.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned MEM_BYTES = MEM_BYTES_DEFAULT,
  parameter int unsigned DATA_W    = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              m0_req_i,
  input  logic              m0_we_i,
  input  logic [31:0]       m0_addr_i,
  input  logic [DATA_W-1:0] m0_wdata_i,
  output logic              m0_gnt_o,
  output logic              m0_rvalid_o,
  output logic [DATA_W-1:0] m0_rdata_o,
  output logic              m0_err_o,
  input  logic              m1_req_i,
  input  logic              m1_we_i,
  input  logic [31:0]       m1_addr_i,
  input  logic [DATA_W-1:0] m1_wdata_i,
  output logic              m1_gnt_o,
  output logic              m1_rvalid_o,
  output logic [DATA_W-1:0] m1_rdata_o,
  output logic              m1_err_o,
  output logic [31:0]       mem_addr_o,
  output logic [DATA_W-1:0] mem_data_o,
  output logic              mem_read_o,
  output logic              mem_write_o,
  input  logic [DATA_W-1:0] mem_data_i
);

  localparam logic [31:0] MAX_ADDR = 32'(MEM_BYTES - 4);

  logic [1:0]        req;
  logic [1:0]        gnt;
  logic [MID_W-1:0]  winner;
  logic              any_gnt;
  logic              sel_we;
  logic [31:0]       sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              legal;

  logic [MID_W-1:0]  prio_q, prio_d;
  resp_state_e       state_q, state_d;
  logic [MID_W-1:0]  resp_id_q, resp_id_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  // Masking requests in reset keeps grants and memory strobes low while rst_i is high.
  assign req = rst_i ? 2'b00 : {m1_req_i, m0_req_i};

  rr_pick2 u_pick (
    .req_i    (req),
    .prio_i   (prio_q),
    .gnt_o    (gnt),
    .winner_o (winner),
    .any_o    (any_gnt)
  );

  assign m0_gnt_o  = gnt[0];
  assign m1_gnt_o  = gnt[1];

  assign sel_we    = winner[0] ? m1_we_i    : m0_we_i;
  assign sel_addr  = winner[0] ? m1_addr_i  : m0_addr_i;
  assign sel_wdata = winner[0] ? m1_wdata_i : m0_wdata_i;
  assign legal     = ((sel_addr[1:0] & ALIGN_MASK) == 2'b00) && (sel_addr <= MAX_ADDR);

  always_comb begin
    mem_addr_o  = '0;
    mem_data_o  = '0;
    mem_read_o  = 1'b0;
    mem_write_o = 1'b0;
    if (any_gnt && legal) begin
      mem_addr_o  = sel_addr;
      mem_data_o  = sel_wdata;
      mem_read_o  = ~sel_we;
      mem_write_o = sel_we;
    end
  end

  // A rejected access is still consumed: it gets an error response instead of a memory cycle.
  always_comb begin
    prio_d    = prio_q;
    state_d   = RESP_NONE;
    resp_id_d = resp_id_q;
    rdata_d   = '0;
    if (any_gnt) begin
      prio_d    = ~winner;
      resp_id_d = winner;
      if (legal) begin
        state_d = RESP_OK;
        rdata_d = sel_we ? '0 : mem_data_i;
      end else begin
        state_d = RESP_ERR;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      // NOTE: the read-data register is reset along with the control state, so rdata is 0 straight out of reset.
      prio_q    <= '0;
      state_q   <= RESP_NONE;
      resp_id_q <= '0;
      rdata_q   <= '0;
    end else begin
      // NOTE: non-blocking assignments here; every register samples its _d value from before the edge.
      prio_q    <= prio_d;
      state_q   <= state_d;
      resp_id_q <= resp_id_d;
      rdata_q   <= rdata_d;
    end
  end

  assign m0_rvalid_o = (state_q != RESP_NONE) && (resp_id_q == 1'b0);
  assign m1_rvalid_o = (state_q != RESP_NONE) && (resp_id_q == 1'b1);
  assign m0_err_o    = (state_q == RESP_ERR)  && (resp_id_q == 1'b0);
  assign m1_err_o    = (state_q == RESP_ERR)  && (resp_id_q == 1'b1);
  assign m0_rdata_o  = m0_rvalid_o ? rdata_q : '0;
  assign m1_rdata_o  = m1_rvalid_o ? rdata_q : '0;

endmodule
